// File: rtl/bus_cycle_controller.sv
// Registered CPU-to-memory bus cycle controller with byte-lane steering, alignment check and timeout.
// Latency: accept to cpu_done is 2 cycles plus one per low bus_ready sample; alignment errors report 1 cycle after accept.
// Backpressure: cpu_start is only sampled in IDLE and never queued; memory stalls the cycle by holding bus_ready low.
package bus_cycle_controller_pkg;
    typedef enum logic [1:0] {
        CW_BYTE = 2'd0,
        CW_WORD = 2'd1,
        CW_LONG = 2'd2
    } t_cycle_width;
endpackage

module bus_cycle_controller
    import bus_cycle_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 16,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_start,
    input  logic [31:0]  cpu_address,
    input  t_cycle_width cpu_cycle_width,
    input  logic         cpu_write,
    input  logic [31:0]  cpu_data_out,
    output logic [31:0]  cpu_data_in,
    output logic         cpu_busy,
    output logic         cpu_done,
    output logic         cpu_bus_error,
    output logic [31:2]  bus_address,
    output logic [31:0]  bus_data_out,
    input  logic [31:0]  bus_data_in,
    output logic [3:0]   bus_data_strobes,
    output logic         bus_read,
    output logic         bus_write,
    input  logic         bus_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;

    // Request captured at accept
    logic [31:0]  addr_q;
    t_cycle_width width_q;
    logic         write_q;
    logic [31:0]  wdata_q;

    logic         accept;
    logic         misaligned;
    logic         qual;

    logic [1:0]   byte_lane;
    logic         word_hi;
    logic [3:0]   lane_strb;
    logic [31:0]  lane_wdata;
    logic [31:0]  lane_rdata;

    logic         read_d, write_d, busy_d, done_d, err_d;
    logic [31:0]  rdata_d;
    logic [31:2]  baddr_d;
    logic [31:0]  bdata_d;
    logic [3:0]   strb_d;

    assign accept = (state_q == S_IDLE) && cpu_start;
    assign qual   = bus_read | bus_write;

    always_comb begin
        misaligned = 1'b0;
        case (cpu_cycle_width)
            CW_BYTE: misaligned = 1'b0;
            CW_WORD: misaligned = cpu_address[0];
            default: misaligned = (cpu_address[1:0] != 2'b00);
        endcase
    end

    // Lane 0 is bits 7:0; big-endian puts offset 0 on the top lane
    always_comb begin
        byte_lane = BIG_ENDIAN ? (2'd3 - addr_q[1:0]) : addr_q[1:0];
        word_hi   = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];
    end

    always_comb begin
        lane_strb  = 4'b1111;
        lane_wdata = wdata_q;
        lane_rdata = bus_data_in;
        case (width_q)
            CW_BYTE: begin
                lane_strb  = 4'b0001 << byte_lane;
                lane_wdata = {4{wdata_q[7:0]}};
                lane_rdata = {24'h0, bus_data_in[{byte_lane, 3'b000} +: 8]};
            end
            CW_WORD: begin
                lane_strb  = word_hi ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
                lane_rdata = {16'h0, (word_hi ? bus_data_in[31:16] : bus_data_in[15:0])};
            end
            default: begin
                lane_strb  = 4'b1111;
                lane_wdata = wdata_q;
                lane_rdata = bus_data_in;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        read_d  = bus_read;
        write_d = bus_write;
        busy_d  = cpu_busy;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = cpu_data_in;
        baddr_d = bus_address;
        bdata_d = bus_data_out;
        strb_d  = bus_data_strobes;

        case (state_q)
            S_IDLE: begin
                if (cpu_start) begin
                    cnt_d   = 8'd0;
                    state_d = misaligned ? S_ERROR : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!qual) begin
                    // First ACCESS cycle launches the registered bus cycle
                    read_d  = ~write_q;
                    write_d = write_q;
                    busy_d  = 1'b1;
                    baddr_d = addr_q[31:2];
                    bdata_d = lane_wdata;
                    strb_d  = lane_strb;
                end else if (bus_ready) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!write_q) begin
                        rdata_d = lane_rdata;
                    end
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_WAIT) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ERROR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                read_d  = 1'b0;
                write_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            cnt_q            <= 8'd0;
            bus_read         <= 1'b0;
            bus_write        <= 1'b0;
            cpu_busy         <= 1'b0;
            cpu_done         <= 1'b0;
            cpu_bus_error    <= 1'b0;
            cpu_data_in      <= 32'h0;
            bus_address      <= 30'h0;
            bus_data_out     <= 32'h0;
            bus_data_strobes <= 4'h0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            bus_read         <= read_d;
            bus_write        <= write_d;
            cpu_busy         <= busy_d;
            cpu_done         <= done_d;
            cpu_bus_error    <= err_d;
            cpu_data_in      <= rdata_d;
            bus_address      <= baddr_d;
            bus_data_out     <= bdata_d;
            bus_data_strobes <= strb_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= 32'h0;
            width_q <= CW_BYTE;
            write_q <= 1'b0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            addr_q  <= cpu_address;
            width_q <= cpu_cycle_width;
            write_q <= cpu_write;
            wdata_q <= cpu_data_out;
        end
    end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench: a big-endian TIMEOUT=4 instance and a little-endian TIMEOUT=16 instance share one stimulus stream.
module tb_bus_cycle_controller;
    import bus_cycle_controller_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cpu_start = 1'b0;
    logic [31:0]  cpu_address = 32'h0;
    t_cycle_width cpu_cycle_width = CW_BYTE;
    logic         cpu_write = 1'b0;
    logic [31:0]  cpu_data_out = 32'h0;
    logic [31:0]  bus_data_in = 32'h0;
    logic         bus_ready = 1'b0;

    logic [31:0]  be_rdata, le_rdata, be_wdat, le_wdat;
    logic [31:2]  be_addr, le_addr;
    logic [3:0]   be_strb, le_strb;
    logic         be_busy, be_done, be_err, be_rd, be_wr;
    logic         le_busy, le_done, le_err, le_rd, le_wr;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bus_cycle_controller #(.TIMEOUT(4), .BIG_ENDIAN(1'b1)) u_be (
        .clock(clock), .reset(reset), .cpu_start(cpu_start), .cpu_address(cpu_address),
        .cpu_cycle_width(cpu_cycle_width), .cpu_write(cpu_write), .cpu_data_out(cpu_data_out),
        .cpu_data_in(be_rdata), .cpu_busy(be_busy), .cpu_done(be_done), .cpu_bus_error(be_err),
        .bus_address(be_addr), .bus_data_out(be_wdat), .bus_data_in(bus_data_in),
        .bus_data_strobes(be_strb), .bus_read(be_rd), .bus_write(be_wr), .bus_ready(bus_ready)
    );

    bus_cycle_controller #(.TIMEOUT(16), .BIG_ENDIAN(1'b0)) u_le (
        .clock(clock), .reset(reset), .cpu_start(cpu_start), .cpu_address(cpu_address),
        .cpu_cycle_width(cpu_cycle_width), .cpu_write(cpu_write), .cpu_data_out(cpu_data_out),
        .cpu_data_in(le_rdata), .cpu_busy(le_busy), .cpu_done(le_done), .cpu_bus_error(le_err),
        .bus_address(le_addr), .bus_data_out(le_wdat), .bus_data_in(bus_data_in),
        .bus_data_strobes(le_strb), .bus_read(le_rd), .bus_write(le_wr), .bus_ready(bus_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Results of the most recent run() as seen on the big-endian instance
    int          r_q, r_lat;
    logic        r_done, r_err, r_both, r_busy_bad, r_rd_seen, r_wr_seen;
    logic [3:0]  r_be_strb, r_le_strb;
    logic [31:0] r_be_wdat, r_le_wdat;
    logic [29:0] r_be_addr;

    // Called at a falling edge; bus_ready rises on qualified cycle waits+1
    task automatic run(input logic [31:0] addr, input t_cycle_width w, input logic wr,
                       input logic [31:0] wd, input int waits);
        cpu_address = addr; cpu_cycle_width = w; cpu_write = wr; cpu_data_out = wd;
        cpu_start = 1'b1; bus_ready = 1'b0;
        @(posedge clock); @(negedge clock);
        cpu_start = 1'b0;
        r_q = 0; r_lat = 0; r_done = 0; r_err = 0; r_both = 0; r_busy_bad = 0;
        r_rd_seen = 0; r_wr_seen = 0;
        r_be_strb = 4'h0; r_le_strb = 4'h0; r_be_wdat = 32'h0; r_le_wdat = 32'h0; r_be_addr = 30'h0;
        while (r_lat < 40 && !r_done && !r_err) begin
            @(posedge clock); @(negedge clock);
            r_lat++;
            r_done = be_done;
            r_err  = be_err;
            if (be_done && be_err) r_both = 1'b1;
            if (be_busy !== (be_rd | be_wr)) r_busy_bad = 1'b1;
            if (le_rd || le_wr) begin
                r_le_strb = le_strb;
                r_le_wdat = le_wdat;
            end
            if (be_rd || be_wr) begin
                r_q++;
                r_rd_seen |= be_rd;
                r_wr_seen |= be_wr;
                r_be_strb = be_strb;
                r_be_wdat = be_wdat;
                r_be_addr = be_addr;
                bus_ready = (r_q > waits);
            end else begin
                bus_ready = 1'b0;
            end
        end
        bus_ready = 1'b0;
    endtask

    initial begin
        int busy_cycles;

        // Reset
        repeat (2) @(negedge clock);
        check("rst_ctl_held", {27'h0, be_done, be_err, be_busy, be_rd, be_wr}, 32'h0);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        check("rst_ctl", {22'h0, be_done, be_err, be_busy, be_rd, be_wr,
                          le_done, le_err, le_busy, le_rd, le_wr}, 32'h0);
        check("rst_rdata", be_rdata | le_rdata, 32'h0);
        check("rst_addr", {2'b00, be_addr | le_addr}, 32'h0);
        check("rst_wdat", be_wdat | le_wdat, 32'h0);
        check("rst_strb", {28'h0, be_strb | le_strb}, 32'h0);

        // Long read, zero wait
        bus_data_in = 32'hDEADBEEF;
        run(32'h0000_1000, CW_LONG, 1'b0, 32'h0, 0);
        check("long_done", {31'h0, r_done}, 32'h1);
        check("long_lat", r_lat, 2);
        check("long_qual", r_q, 1);
        check("long_rd", {30'h0, r_rd_seen, r_wr_seen}, 32'h2);
        check("long_addr", {2'b00, r_be_addr}, 32'h400);
        check("long_strb", {28'h0, r_be_strb}, 32'hF);
        check("long_rdata", be_rdata, 32'hDEADBEEF);
        check("long_busy", {31'h0, r_busy_bad | be_busy}, 32'h0);

        // Back-to-back byte write with 3 wait cycles
        run(32'h0000_0003, CW_BYTE, 1'b1, 32'h0000_00A5, 3);
        check("bw_done", {30'h0, r_done, r_err}, 32'h2);
        check("bw_lat", r_lat, 5);
        check("bw_qual", r_q, 4);
        check("bw_wr", {30'h0, r_rd_seen, r_wr_seen}, 32'h1);
        check("bw_strb_be", {28'h0, r_be_strb}, 32'h1);
        check("bw_strb_le", {28'h0, r_le_strb}, 32'h8);
        check("bw_wdat", r_be_wdat, 32'hA5A5A5A5);
        check("bw_rdata_kept", be_rdata, 32'hDEADBEEF);

        // Word reads at offsets 2 and 0
        bus_data_in = 32'h1234ABCD;
        run(32'h0000_0002, CW_WORD, 1'b0, 32'h0, 0);
        check("w2_strb_be", {28'h0, r_be_strb}, 32'h3);
        check("w2_rdata_be", be_rdata, 32'h0000ABCD);
        check("w2_strb_le", {28'h0, r_le_strb}, 32'hC);
        check("w2_rdata_le", le_rdata, 32'h00001234);
        run(32'h0000_0000, CW_WORD, 1'b0, 32'h0, 1);
        check("w0_strb_le", {28'h0, r_le_strb}, 32'h3);
        check("w0_rdata_le", le_rdata, 32'h0000ABCD);
        check("w0_strb_be", {28'h0, r_be_strb}, 32'hC);
        check("w0_rdata_be", be_rdata, 32'h00001234);

        // Byte read at offset 1
        bus_data_in = 32'h11223344;
        run(32'h0000_0001, CW_BYTE, 1'b0, 32'h0, 0);
        check("b1_strb_be", {28'h0, r_be_strb}, 32'h4);
        check("b1_rdata_be", be_rdata, 32'h00000022);
        check("b1_strb_le", {28'h0, r_le_strb}, 32'h2);
        check("b1_rdata_le", le_rdata, 32'h00000033);

        // Word write: upper input half ignored, value replicated
        run(32'h0000_0102, CW_WORD, 1'b1, 32'h1234BEEF, 0);
        check("ww_wdat", r_be_wdat, 32'hBEEFBEEF);
        check("ww_strb_be", {28'h0, r_be_strb}, 32'h3);
        check("ww_strb_le", {28'h0, r_le_strb}, 32'hC);
        check("ww_wdat_le", r_le_wdat, 32'hBEEFBEEF);

        // Misaligned requests
        run(32'h0000_0006, CW_LONG, 1'b0, 32'h0, 0);
        check("mis_l_err", {30'h0, r_done, r_err}, 32'h1);
        check("mis_l_lat", r_lat, 1);
        check("mis_l_qual", r_q, 0);
        check("mis_l_rdata", be_rdata, 32'h00000022);
        run(32'h0000_0009, CW_WORD, 1'b1, 32'h0, 0);
        check("mis_w_err", {30'h0, r_done, r_err}, 32'h1);
        check("mis_w_qual", r_q, 0);
        @(posedge clock); @(negedge clock);
        check("mis_err_pulse", {31'h0, be_err}, 32'h0);

        // Timeout with bus_ready held low
        bus_data_in = 32'h55555555;
        run(32'h0000_0020, CW_LONG, 1'b0, 32'h0, 100);
        check("to_err", {29'h0, r_both, r_done, r_err}, 32'h1);
        check("to_qual", r_q, 4);
        check("to_lat", r_lat, 5);
        check("to_rdata", be_rdata, 32'h00000022);
        repeat (20) @(negedge clock);
        check("to_le_idle", {31'h0, le_busy}, 32'h0);
        check("to_le_rdata", le_rdata, 32'h00000033);

        // Ready on the last allowed cycle completes
        bus_data_in = 32'hCAFEF00D;
        run(32'h0000_0040, CW_LONG, 1'b0, 32'h0, 3);
        check("edge_done", {29'h0, r_both, r_done, r_err}, 32'h2);
        check("edge_qual", r_q, 4);
        check("edge_rdata", be_rdata, 32'hCAFEF00D);

        // cpu_start held through ACCESS is not queued
        cpu_address = 32'h80; cpu_cycle_width = CW_LONG; cpu_write = 1'b0; cpu_start = 1'b1;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        cpu_start = 1'b0;
        check("hold_rd", {31'h0, be_rd}, 32'h1);
        bus_ready = 1'b1;
        @(posedge clock); @(negedge clock);
        bus_ready = 1'b0;
        check("hold_done", {31'h0, be_done}, 32'h1);
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); @(negedge clock);
            if (be_busy || be_rd || be_wr) busy_cycles++;
        end
        check("hold_no_queue", busy_cycles, 0);

        // Reset in the middle of a bus cycle
        bus_data_in = 32'h0;
        cpu_address = 32'h100; cpu_start = 1'b1;
        @(posedge clock); @(negedge clock);
        cpu_start = 1'b0;
        @(posedge clock); @(negedge clock);
        check("mid_rd_before", {31'h0, be_rd}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("mid_rd_async", {28'h0, be_rd, be_busy, be_done, be_err}, 32'h0);
        check("mid_rdata_async", be_rdata, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        check("mid_after", {27'h0, be_done, be_err, be_busy, be_rd, be_wr}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
